quant_serializer: RTL and testbench



---
 rtl/quant_serializer_if.sv | 17 +
 rtl/quant_serializer.sv | 111 +++++++++++
 tb/tb_quant_serializer.sv | 111 +++++++++++
 3 files changed

// File: rtl/quant_serializer_if.sv
// rtl/quant_serializer_if.sv - field-select/control inputs and serial output of quant_serializer
interface quant_serializer_if #(
   parameter int BDIN     = 32,
   parameter int BDOUTMAX = 32
);
   localparam int MAXBDIP = $clog2(BDIN);
   localparam int MAXBDOP = $clog2(BDOUTMAX);

   logic [MAXBDIP-1:0] msbidx;
   logic [MAXBDOP-1:0] bdout;
   logic               start;
   logic [BDIN-1:0]    din;
   logic               dout;

   modport master (output msbidx, bdout, start, din, input dout);
   modport slave  (input msbidx, bdout, start, din, output dout);
endinterface

// File: rtl/quant_serializer.sv
// rtl/quant_serializer.sv - truncating bit-field serializer, MSB first, one bit per clock
// Define QUANTSER_ROUND_EN to round the field half-up (saturating) at load.
module quant_serializer #(
   parameter int BDIN     = 32,
   parameter int BDOUTMAX = 32,
   parameter int MAXBDIP  = $clog2(BDIN),
   parameter int MAXBDOP  = $clog2(BDOUTMAX)
) (
   input logic               clk,
   input logic               clr,
   quant_serializer_if.slave bus
);

   typedef enum logic {S_IDLE, S_SHIFT} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_start_q;
   logic                r_dout;
   logic [MAXBDOP-1:0]  r_cnt;
   logic [BDOUTMAX-1:0] r_sr;

   logic                w_trig;
   logic [MAXBDIP-1:0]  w_msb;
   logic [MAXBDOP-1:0]  w_bd;
   logic [BDOUTMAX-1:0] w_fld;
   logic [BDOUTMAX-1:0] w_load;
   logic                w_dout_nxt;
   logic [MAXBDOP-1:0]  w_cnt_nxt;
   logic [BDOUTMAX-1:0] w_sr_nxt;

   assign w_trig  = bus.start & ~r_start_q;
   assign bus.dout = r_dout;

   always_comb begin
      w_msb = (int'(bus.msbidx) >= BDIN)    ? MAXBDIP'(BDIN - 1)     : bus.msbidx;
      w_bd  = (int'(bus.bdout)  >= BDOUTMAX) ? MAXBDOP'(BDOUTMAX - 1) : bus.bdout;
   end

   // Field is left-aligned in w_fld; positions below din[0] stay 0 (underflow).
   always_comb begin
      w_fld = '0;
      for (int k = 0; k < BDOUTMAX; k++) begin
         if (k <= int'(w_bd) && k <= int'(w_msb))
            w_fld[BDOUTMAX-1-k] = bus.din[w_msb - MAXBDIP'(k)];
      end
   end

`ifdef QUANTSER_ROUND_EN
   int                  w_rpos;
   logic                w_rbit;
   logic [BDOUTMAX:0]   w_lsb;
   logic [BDOUTMAX:0]   w_sum;
   logic [BDOUTMAX-1:0] w_mask;

   always_comb begin
      w_rpos = int'(w_msb) - int'(w_bd) - 1;
      w_rbit = (w_rpos >= 0) ? bus.din[w_rpos[MAXBDIP-1:0]] : 1'b0;
      w_lsb  = {{BDOUTMAX{1'b0}}, 1'b1} << (BDOUTMAX - 1 - int'(w_bd));
      w_sum  = {1'b0, w_fld} + (w_rbit ? w_lsb : '0);
      w_mask = ~({BDOUTMAX{1'b1}} >> (int'(w_bd) + 1));
      w_load = w_sum[BDOUTMAX] ? w_mask : w_sum[BDOUTMAX-1:0];
   end
`else
   assign w_load = w_fld;
`endif

   always_ff @(posedge clk) begin
      if (clr) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_trig)
         w_state_nxt = S_SHIFT;
      else if (r_state == S_SHIFT && r_cnt == '0)
         w_state_nxt = S_IDLE;
   end

   // A trigger always wins, so a retrigger abandons the running sequence.
   always_comb begin
      w_dout_nxt = 1'b0;
      w_cnt_nxt  = r_cnt;
      w_sr_nxt   = r_sr;
      if (w_trig) begin
         w_dout_nxt = w_load[BDOUTMAX-1];
         w_sr_nxt   = w_load << 1;
         w_cnt_nxt  = w_bd;
      end else if (r_state == S_SHIFT && r_cnt != '0) begin
         w_dout_nxt = r_sr[BDOUTMAX-1];
         w_sr_nxt   = r_sr << 1;
         w_cnt_nxt  = r_cnt - MAXBDOP'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         r_start_q <= 1'b0;
         r_dout    <= 1'b0;
         r_cnt     <= '0;
         r_sr      <= '0;
      end else begin
         r_start_q <= bus.start;
         r_dout    <= w_dout_nxt;
         r_cnt     <= w_cnt_nxt;
         r_sr      <= w_sr_nxt;
      end
   end

endmodule

// File: tb/tb_quant_serializer.sv
// tb/tb_quant_serializer.sv - directed self-checking bench for quant_serializer
module tb_quant_serializer;

   logic clk = 1'b0;
   logic clr = 1'b1;
   int   checks = 0;
   int   errors = 0;

   quant_serializer_if #(.BDIN(32), .BDOUTMAX(32)) qif ();

   quant_serializer #(.BDIN(32), .BDOUTMAX(32)) dut (
      .clk (clk),
      .clr (clr),
      .bus (qif.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input logic obs, input logic exp, input string tag);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Trigger one sequence, scramble inputs after load, check n bits then two idle zeros.
   task automatic seq(input logic [31:0] d, input logic [4:0] m, input logic [4:0] b,
                      input logic [39:0] e, input int n, input string tag);
      @(negedge clk);
      qif.din = d; qif.msbidx = m; qif.bdout = b; qif.start = 1'b1;
      @(negedge clk);
      qif.start = 1'b0; qif.din = ~d; qif.msbidx = ~m; qif.bdout = ~b;
      for (int k = 0; k < n + 2; k++) begin
         check(qif.dout, (k < n) ? e[n-1-k] : 1'b0, $sformatf("%s[%0d]", tag, k));
         @(negedge clk);
      end
   endtask

   initial begin
      qif.din = 32'hFFFF_FFFF; qif.msbidx = 5'd31; qif.bdout = 5'd7; qif.start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check(qif.dout, 1'b0, "reset");
      end
      clr = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check(qif.dout, 1'b0, "no_start");
      end

      seq(32'h1,         5'd0,  5'd0,  40'b1,  1,  "bd0_m0");
      seq(32'h8,         5'd3,  5'd0,  40'b1,  1,  "bd0_m3");
      seq(32'h8000_0000, 5'd31, 5'd0,  40'b1,  1,  "bd0_m31");
      seq(32'h2,         5'd1,  5'd1,  40'b10, 2,  "bd1_m1");
      seq(32'h8,         5'd3,  5'd1,  40'b10, 2,  "bd1_m3");
      seq(32'h8000_0000, 5'd31, 5'd1,  40'b10, 2,  "bd1_m31");
      seq(32'h5,         5'd31, 5'd31, 40'h5,  32, "bd31_m31");
      seq(32'h3,         5'd1,  5'd3,  40'b1100, 4, "underflow");
`ifdef QUANTSER_ROUND_EN
      seq(32'b0110,      5'd3,  5'd1,  40'b10, 2,  "round_up");
`else
      seq(32'b0110,      5'd3,  5'd1,  40'b01, 2,  "trunc");
`endif
      seq(32'b1110,      5'd3,  5'd1,  40'b11, 2,  "saturate");

      // Retrigger mid-sequence: 0xFF field abandoned after three bits.
      @(negedge clk);
      qif.din = 32'hFF; qif.msbidx = 5'd7; qif.bdout = 5'd7; qif.start = 1'b1;
      @(negedge clk);
      qif.start = 1'b0;
      check(qif.dout, 1'b1, "retrig_old0");
      @(negedge clk);
      check(qif.dout, 1'b1, "retrig_old1");
      @(negedge clk);
      check(qif.dout, 1'b1, "retrig_old2");
      qif.din = 32'hA; qif.msbidx = 5'd3; qif.bdout = 5'd3; qif.start = 1'b1;
      @(negedge clk);
      qif.start = 1'b0;
      for (int k = 0; k < 6; k++) begin
         check(qif.dout, (k < 4) ? ((k % 2) == 0) : 1'b0, $sformatf("retrig_new[%0d]", k));
         @(negedge clk);
      end

      // Start held high for five cycles yields a single 1,1 sequence.
      qif.din = 32'h3; qif.msbidx = 5'd1; qif.bdout = 5'd1; qif.start = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 7; k++) begin
         if (k == 4) qif.start = 1'b0;
         check(qif.dout, k < 2, $sformatf("hold[%0d]", k));
         @(negedge clk);
      end

      // clr aborts a running sequence.
      qif.din = 32'hFF; qif.msbidx = 5'd7; qif.bdout = 5'd7; qif.start = 1'b1;
      @(negedge clk);
      qif.start = 1'b0;
      check(qif.dout, 1'b1, "abort_pre");
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check(qif.dout, 1'b0, $sformatf("abort[%0d]", k));
         @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
